ast_arb_mux: RTL and testbench

//  Avalon-ST packet multiplexer: merges CHANNELS_CNT input streams into one output stream.

---
 rtl/ast_arb_mux.sv | 90 +++++++++
 tb/tb_ast_arb_mux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_arb_mux.sv
// ast_arb_mux: round-robin, packet-atomic Avalon-ST multiplexer with source index on the channel field
module ast_arb_mux #(
  parameter int DATA_W       = 64,
  parameter int CHANNELS_CNT = 4,
  parameter int EMPTY_W      = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1,
  parameter int CHANNEL_W    = (CHANNELS_CNT > 1) ? $clog2(CHANNELS_CNT) : 1
) (
  input  logic                              clk_i,
  input  logic                              srst_i,
  input  logic [CHANNELS_CNT*DATA_W-1:0]    ast_data_i,
  input  logic [CHANNELS_CNT-1:0]           ast_startofpacket_i,
  input  logic [CHANNELS_CNT-1:0]           ast_endofpacket_i,
  input  logic [CHANNELS_CNT-1:0]           ast_valid_i,
  input  logic [CHANNELS_CNT*EMPTY_W-1:0]   ast_empty_i,
  output logic [CHANNELS_CNT-1:0]           ast_ready_o,
  output logic [DATA_W-1:0]                 ast_data_o,
  output logic                              ast_startofpacket_o,
  output logic                              ast_endofpacket_o,
  output logic                              ast_valid_o,
  output logic [EMPTY_W-1:0]                ast_empty_o,
  output logic [CHANNEL_W-1:0]              ast_channel_o,
  input  logic                              ast_ready_i
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t               state_q;
  logic [CHANNEL_W-1:0] grant_q, grant_d, rr_q, channel_q;
  logic [DATA_W-1:0]    data_q;
  logic [EMPTY_W-1:0]   empty_q;
  logic                 sop_q, eop_q, valid_q, load;
  logic [DATA_W-1:0]    data_a  [CHANNELS_CNT];
  logic [EMPTY_W-1:0]   empty_a [CHANNELS_CNT];
  genvar k;
  generate
    for (k = 0; k < CHANNELS_CNT; k++) begin : g_split
      assign data_a[k]  = ast_data_i[k*DATA_W +: DATA_W];
      assign empty_a[k] = ast_empty_i[k*EMPTY_W +: EMPTY_W];
    end
  endgenerate
  function automatic logic [CHANNEL_W-1:0] wrap(input int v);
    return CHANNEL_W'(v % CHANNELS_CNT);
  endfunction
  // Scan from farthest to nearest so the first requester after the pointer wins.
  always_comb begin
    grant_d = rr_q;
    for (int i = CHANNELS_CNT; i >= 1; i--)
      grant_d = ast_valid_i[wrap(int'(rr_q) + i)] ? wrap(int'(rr_q) + i) : grant_d;
  end
  always_comb begin
    ast_ready_o          = '0;
    ast_ready_o[grant_q] = (state_q == PKT) && (!valid_q || ast_ready_i);
  end
  assign load = ast_ready_o[grant_q] && ast_valid_i[grant_q];
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= CHANNEL_W'(CHANNELS_CNT - 1);
      valid_q   <= 1'b0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
      channel_q <= '0;
    end else begin
      if (load) begin
        valid_q   <= 1'b1;
        data_q    <= data_a[grant_q];
        sop_q     <= ast_startofpacket_i[grant_q];
        eop_q     <= ast_endofpacket_i[grant_q];
        empty_q   <= empty_a[grant_q];
        channel_q <= grant_q;
      end else if (ast_ready_i) begin
        valid_q <= 1'b0;
      end
      if (state_q == IDLE && |ast_valid_i) begin
        grant_q <= grant_d;
        state_q <= PKT;
      end else if (load && ast_endofpacket_i[grant_q]) begin
        rr_q    <= grant_q;
        state_q <= IDLE;
      end
    end
  end
  assign ast_valid_o         = valid_q;
  assign ast_data_o          = data_q;
  assign ast_startofpacket_o = sop_q;
  assign ast_endofpacket_o   = eop_q;
  assign ast_empty_o         = empty_q;
  assign ast_channel_o       = channel_q;
endmodule

// File: tb/tb_ast_arb_mux.sv
// tb_ast_arb_mux: directed and randomized-traffic bench with per-channel scoreboard for ast_arb_mux
module tb_ast_arb_mux;
  localparam int DW = 64, N = 4, EW = 3, CW = 2;
  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  logic            clk = 1'b0, srst_i = 1'b1;
  logic [N*DW-1:0] ast_data_i = '0;
  logic [N-1:0]    ast_startofpacket_i = '0, ast_endofpacket_i = '0, ast_valid_i = '0;
  logic [N*EW-1:0] ast_empty_i = '0;
  logic [N-1:0]    ast_ready_o;
  logic [DW-1:0]   ast_data_o;
  logic            ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
  logic [EW-1:0]   ast_empty_o;
  logic [CW-1:0]   ast_channel_o;
  logic            ast_ready_i = 1'b1;

  ast_arb_mux #(.DATA_W(DW), .CHANNELS_CNT(N)) dut (
    .clk_i(clk), .srst_i(srst_i),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .ast_ready_i(ast_ready_i)
  );

  initial forever #5 clk = ~clk;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  beat_t out_q [$];
  int    n_chk = 0, n_err = 0;
  int    ready_mode = 0;
  bit    gap_en = 1'b0;
  logic  rst_edge = 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rst_edge <= srst_i;

  // ready_mode: 0 = always ready, 1 = random 50%, 2 = stalled
  initial forever begin
    @(posedge clk); #1;
    ast_ready_i = (ready_mode == 1) ? 1'($urandom) : (ready_mode == 0);
  end

  // source drivers: hold a beat until accepted, optionally insert valid gaps
  initial begin
    logic [N-1:0] fire;
    forever begin
      @(negedge clk);
      fire = ast_valid_i & ast_ready_o;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() == 0) ast_valid_i[k] = 1'b0;
        else if (!(ast_valid_i[k] && !fire[k])) begin
          ast_valid_i[k]              = !(gap_en && ($urandom % 4 == 0));
          ast_data_i[k*DW +: DW]      = src_q[k][0].data;
          ast_startofpacket_i[k]      = src_q[k][0].sop;
          ast_endofpacket_i[k]        = src_q[k][0].eop;
          ast_empty_i[k*EW +: EW]     = src_q[k][0].empty;
        end
      end
    end
  end

  // output monitor: record transfers, check stability while stalled
  initial begin
    beat_t cur, prev;
    logic  held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {ast_channel_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o};
      if (held && !rst_edge) begin
        check("stable_valid", 128'(ast_valid_o), 128'(1));
        check("stable_fields", 128'(cur), 128'(prev));
      end
      if (ast_valid_o && ast_ready_i) out_q.push_back(cur);
      held = ast_valid_o && !ast_ready_i && !srst_i;
      prev = cur;
    end
  end

  task automatic push_pkt(input int ch, input int len, input int id, input bit rnd_empty);
    for (int b = 0; b < len; b++) begin
      beat_t t;
      t.ch    = CW'(ch);
      t.data  = {16'(id), 16'(ch), 16'(b), 16'($urandom)};
      t.sop   = (b == 0);
      t.eop   = (b == len - 1);
      t.empty = rnd_empty ? EW'($urandom) : EW'(b);
      src_q[ch].push_back(t);
      exp_q[ch].push_back(t);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    repeat (2) @(negedge clk);
    srst_i = 1'b0;
    out_q.delete();
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("beat_cnt", 128'(out_q.size()), 128'(n));
  endtask

  task automatic score();
    while (out_q.size() > 0) begin
      beat_t b;
      b = out_q.pop_front();
      if (exp_q[b.ch].size() > 0) check("sb_beat", 128'(b), 128'(exp_q[b.ch].pop_front()));
      else check("sb_extra", 128'(b), 128'(0));
    end
    for (int k = 0; k < N; k++) check("sb_left", 128'(exp_q[k].size()), 128'(0));
  endtask

  initial begin
    int    ord[3];
    int    cnt[N];
    int    total;
    beat_t t;
    ord = '{0, 1, 3};

    // reset state
    do_reset();
    check("rst_valid", 128'(ast_valid_o), 128'(0));
    check("rst_ready", 128'(ast_ready_o), 128'(0));
    check("rst_fields", 128'({ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o}), 128'(0));

    // single-beat packet on input 2
    t = '{ch: 2'd2, data: 64'hAB, sop: 1'b1, eop: 1'b1, empty: 3'd7};
    src_q[2].push_back(t);
    exp_q[2].push_back(t);
    wait_out(1, 50);
    check("t1_data", 128'(out_q[0].data), 128'h00AB);
    check("t1_sop", 128'(out_q[0].sop), 128'(1));
    check("t1_eop", 128'(out_q[0].eop), 128'(1));
    check("t1_empty", 128'(out_q[0].empty), 128'(7));
    check("t1_ch", 128'(out_q[0].ch), 128'(2));
    score();

    // simultaneous 3-beat packets on inputs 0,1,3
    do_reset();
    push_pkt(0, 3, 20, 0);
    push_pkt(1, 3, 21, 0);
    push_pkt(3, 3, 23, 0);
    wait_out(9, 100);
    for (int i = 0; i < 9; i++) begin
      check("t2_ch", 128'(out_q[i].ch), 128'(ord[i / 3]));
      check("t2_sop_eop", 128'({out_q[i].sop, out_q[i].eop}), 128'({i % 3 == 0, i % 3 == 2}));
    end
    score();

    // all four inputs saturated with 2-beat packets
    do_reset();
    for (int p = 0; p < 10; p++)
      for (int c = 0; c < N; c++) push_pkt(c, 2, 100 + p, 1);
    wait_out(80, 600);
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int p = 0; p < 40; p++) begin
      check("t3_grant", 128'(out_q[2*p].ch), 128'(p % 4));
      check("t3_contig", 128'(out_q[2*p+1].ch), 128'(p % 4));
      cnt[out_q[2*p].ch]++;
    end
    for (int k = 0; k < N; k++) check("t3_pkts", 128'(cnt[k]), 128'(10));
    score();

    // random backpressure and source gaps
    do_reset();
    ready_mode = 1;
    gap_en = 1'b1;
    total = 0;
    for (int p = 0; p < 200; p++) begin
      int len;
      len = 1 + int'($urandom % 16);
      push_pkt(int'($urandom % N), len, 1000 + p, 1);
      total += len;
    end
    wait_out(total, 40000);
    score();
    ready_mode = 0;
    gap_en = 1'b0;

    // reset in the middle of a packet on input 1
    do_reset();
    push_pkt(1, 5, 50, 0);
    for (int i = 0; i < 50 && !(ast_valid_i[1] && ast_data_i[DW+16 +: 16] == 16'd2); i++) @(negedge clk);
    check("t5_beat3_seen", 128'(ast_data_i[DW+16 +: 16]), 128'(2));
    srst_i = 1'b1;
    src_q[1].delete();
    @(negedge clk);
    check("t5_valid_o", 128'(ast_valid_o), 128'(0));
    check("t5_ready_o", 128'(ast_ready_o), 128'(0));
    srst_i = 1'b0;
    out_q.delete();
    for (int k = 0; k < N; k++) exp_q[k].delete();
    push_pkt(1, 2, 51, 0);
    push_pkt(0, 2, 52, 0);
    wait_out(4, 50);
    check("t5_first_ch", 128'(out_q[0].ch), 128'(0));
    check("t5_second_ch", 128'(out_q[2].ch), 128'(1));
    score();

    // stalled downstream while input 0 streams
    do_reset();
    ready_mode = 2;
    push_pkt(0, 16, 60, 0);
    repeat (12) @(negedge clk);
    check("t6_ready_o0", 128'(ast_ready_o[0]), 128'(0));
    check("t6_valid_o", 128'(ast_valid_o), 128'(1));
    check("t6_no_out", 128'(out_q.size()), 128'(0));
    check("t6_held_beat", 128'(ast_data_o[31:16]), 128'(0));
    ready_mode = 0;
    wait_out(16, 100);
    score();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
